rf_wb_arb: RTL and testbench

Writeback arbiter and scoreboard for the 16x16 triple-ported register file. It merges two writeback sources, the ALU and the memory-load path, onto the file's single write port. Each source has its own small FIFO, and a round-robin grant picks which source writes each cycle. A 16-bit pending scoreboard flags read-after-write hazards to the decode stage, so decode stalls instead of reading stale data.

---
 rtl/rf_wb_arb.sv | 203 ++++++++++++++++++++
 tb/tb_rf_wb_arb.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arb.sv
// Writeback arbiter for the register file: two per-source FIFOs merged
// round-robin onto one registered write port, plus a pending-write scoreboard.

module rf_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         rdy,
    output logic         ne,
    output logic [W-1:0] head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by cnt_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdy  = (cnt_q < FULL);
    assign ne   = (cnt_q != '0);
    assign head = mem_q[rd_ptr_q];
endmodule

module rf_wb_arb #(
    parameter int DEPTH = 2,
    parameter int DW    = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_vld,
    input  logic [AW-1:0] alu_dst,
    input  logic [DW-1:0] alu_data,
    output logic          alu_rdy,
    input  logic          mem_vld,
    input  logic [AW-1:0] mem_dst,
    input  logic [DW-1:0] mem_data,
    output logic          mem_rdy,
    output logic          rf_we,
    output logic [AW-1:0] rf_dst_addr,
    output logic [DW-1:0] rf_dst,
    input  logic          iss_vld,
    input  logic [AW-1:0] iss_dst,
    output logic          iss_hazard,
    input  logic [AW-1:0] rd0_addr,
    input  logic [AW-1:0] rd1_addr,
    output logic          hazard0,
    output logic          hazard1,
    output logic          idle
);
    localparam int EW   = AW + DW;
    localparam int NREG = 2 ** AW;

    typedef enum logic {
        GNT_MEM = 1'b0,
        GNT_ALU = 1'b1
    } grant_e;

    grant_e          last_grant_q, last_grant_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_dst_addr_q, rf_dst_addr_d;
    logic [DW-1:0]   rf_dst_q, rf_dst_d;
    logic [NREG-1:0] pending_q, pending_d;

    logic          alu_push, alu_pop, alu_ne;
    logic          mem_push, mem_pop, mem_ne;
    logic [EW-1:0] alu_head, mem_head, win;
    logic [AW-1:0] win_dst;
    logic [DW-1:0] win_data;

    assign alu_push = alu_vld & alu_rdy;
    assign mem_push = mem_vld & mem_rdy;

    rf_wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_alu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (alu_push),
        .push_data ({alu_dst, alu_data}),
        .pop       (alu_pop),
        .rdy       (alu_rdy),
        .ne        (alu_ne),
        .head      (alu_head)
    );

    rf_wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_mem_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (mem_push),
        .push_data ({mem_dst, mem_data}),
        .pop       (mem_pop),
        .rdy       (mem_rdy),
        .ne        (mem_ne),
        .head      (mem_head)
    );

    always_comb begin
        alu_pop      = 1'b0;
        mem_pop      = 1'b0;
        last_grant_d = last_grant_q;
        if (alu_ne && (!mem_ne || last_grant_q == GNT_MEM)) begin
            alu_pop      = 1'b1;
            last_grant_d = GNT_ALU;
        end else if (mem_ne) begin
            mem_pop      = 1'b1;
            last_grant_d = GNT_MEM;
        end

        win      = alu_pop ? alu_head : mem_head;
        win_dst  = win[EW-1:DW];
        win_data = win[DW-1:0];

        // R0 entries still consume the grant but never reach the file.
        rf_we_d       = (alu_pop | mem_pop) && (win_dst != '0);
        rf_dst_addr_d = rf_dst_addr_q;
        rf_dst_d      = rf_dst_q;
        if (rf_we_d) begin
            rf_dst_addr_d = win_dst;
            rf_dst_d      = win_data;
        end

        pending_d = pending_q;
        if (rf_we_q && rf_dst_addr_q != '0) begin
            pending_d[rf_dst_addr_q] = 1'b0;
        end
        if (iss_vld && iss_dst != '0) begin
            pending_d[iss_dst] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q  <= GNT_MEM;
            rf_we_q       <= 1'b0;
            rf_dst_addr_q <= '0;
            rf_dst_q      <= '0;
            pending_q     <= '0;
        end else begin
            last_grant_q  <= last_grant_d;
            rf_we_q       <= rf_we_d;
            rf_dst_addr_q <= rf_dst_addr_d;
            rf_dst_q      <= rf_dst_d;
            pending_q     <= pending_d;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_dst_addr = rf_dst_addr_q;
    assign rf_dst      = rf_dst_q;

    // The file bypasses a same-cycle write, so that register is not a hazard.
    assign hazard0 = pending_q[rd0_addr] & ~(rf_we_q & (rf_dst_addr_q == rd0_addr))
                     & (rd0_addr != '0);
    assign hazard1 = pending_q[rd1_addr] & ~(rf_we_q & (rf_dst_addr_q == rd1_addr))
                     & (rd1_addr != '0);
    assign iss_hazard = pending_q[iss_dst] & (iss_dst != '0);

    assign idle = ~alu_ne & ~mem_ne & ~rf_we_q;
endmodule

// File: tb/tb_rf_wb_arb.sv
// Bench for rf_wb_arb: directed scenarios plus a randomized run checked
// against a queue-based reference model.

module tb_rf_wb_arb;
    localparam int DEPTH = 2;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int NREG  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          alu_vld, mem_vld, iss_vld;
    logic [AW-1:0] alu_dst, mem_dst, iss_dst, rd0_addr, rd1_addr;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_rdy, mem_rdy, rf_we, iss_hazard, hazard0, hazard1, idle;
    logic [AW-1:0] rf_dst_addr;
    logic [DW-1:0] rf_dst;

    int total = 0;
    int bad   = 0;

    rf_wb_arb #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_vld     (alu_vld),
        .alu_dst     (alu_dst),
        .alu_data    (alu_data),
        .alu_rdy     (alu_rdy),
        .mem_vld     (mem_vld),
        .mem_dst     (mem_dst),
        .mem_data    (mem_data),
        .mem_rdy     (mem_rdy),
        .rf_we       (rf_we),
        .rf_dst_addr (rf_dst_addr),
        .rf_dst      (rf_dst),
        .iss_vld     (iss_vld),
        .iss_dst     (iss_dst),
        .iss_hazard  (iss_hazard),
        .rd0_addr    (rd0_addr),
        .rd1_addr    (rd1_addr),
        .hazard0     (hazard0),
        .hazard1     (hazard1),
        .idle        (idle)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_vld = 0; alu_dst = '0; alu_data = '0;
        mem_vld = 0; mem_dst = '0; mem_data = '0;
        iss_vld = 0; iss_dst = '0; rd0_addr = '0; rd1_addr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        next_cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        alu_vld = 1; alu_dst = 4'd3; alu_data = 16'h1234;
        iss_vld = 1; iss_dst = 4'd3;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 0;
        idle_inputs();
        rd0_addr = 4'd3; rd1_addr = 4'd4; iss_dst = 4'd3;
        #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b exp=0", rf_we); end
        total++; if (rf_dst_addr !== 4'd0) begin bad++; $display("FAIL rst_addr got=%0h exp=0", rf_dst_addr); end
        total++; if (rf_dst !== 16'd0) begin bad++; $display("FAIL rst_data got=%0h exp=0", rf_dst); end
        total++; if (alu_rdy !== 1'b1) begin bad++; $display("FAIL rst_alu_rdy got=%0b exp=1", alu_rdy); end
        total++; if (mem_rdy !== 1'b1) begin bad++; $display("FAIL rst_mem_rdy got=%0b exp=1", mem_rdy); end
        total++; if (hazard0 !== 1'b0) begin bad++; $display("FAIL rst_hz0 got=%0b exp=0", hazard0); end
        total++; if (hazard1 !== 1'b0) begin bad++; $display("FAIL rst_hz1 got=%0b exp=0", hazard1); end
        total++; if (iss_hazard !== 1'b0) begin bad++; $display("FAIL rst_iss_hz got=%0b exp=0", iss_hazard); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle got=%0b exp=1", idle); end
    endtask

    task automatic test_single_alu();
        do_reset();
        iss_vld = 1; iss_dst = 4'd5; rd0_addr = 4'd5;
        next_cycle();
        iss_vld = 0; alu_vld = 1; alu_dst = 4'd5; alu_data = 16'hBEEF;
        #1;
        total++; if (hazard0 !== 1'b1) begin bad++; $display("FAIL single_hz_c1 got=%0b exp=1", hazard0); end
        total++; if (alu_rdy !== 1'b1) begin bad++; $display("FAIL single_rdy_c1 got=%0b exp=1", alu_rdy); end
        next_cycle();
        alu_vld = 0;
        #1;
        total++; if (hazard0 !== 1'b1) begin bad++; $display("FAIL single_hz_c2 got=%0b exp=1", hazard0); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL single_we_c2 got=%0b exp=0", rf_we); end
        total++; if (iss_hazard !== 1'b1) begin bad++; $display("FAIL single_iss_hz_c2 got=%0b exp=1", iss_hazard); end
        next_cycle();
        #1;
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL single_we_c3 got=%0b exp=1", rf_we); end
        total++; if (rf_dst_addr !== 4'd5) begin bad++; $display("FAIL single_addr_c3 got=%0h exp=5", rf_dst_addr); end
        total++; if (rf_dst !== 16'hBEEF) begin bad++; $display("FAIL single_data_c3 got=%0h exp=beef", rf_dst); end
        total++; if (hazard0 !== 1'b0) begin bad++; $display("FAIL single_bypass_c3 got=%0b exp=0", hazard0); end
        next_cycle();
        #1;
        total++; if (hazard0 !== 1'b0) begin bad++; $display("FAIL single_hz_c4 got=%0b exp=0", hazard0); end
        total++; if (iss_hazard !== 1'b0) begin bad++; $display("FAIL single_iss_hz_c4 got=%0b exp=0", iss_hazard); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL single_we_c4 got=%0b exp=0", rf_we); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle_c4 got=%0b exp=1", idle); end
    endtask

    task automatic test_tie_rr();
        int ai, mi;
        int wcyc[$];
        logic [DW-1:0] wdat[$];
        logic [DW-1:0] exp_d;
        do_reset();
        ai = 0; mi = 0;
        for (int c = 0; c < 12; c++) begin
            alu_vld = (ai < 3); alu_dst = AW'(ai + 1); alu_data = 16'hA000 + 16'(ai);
            mem_vld = (mi < 3); mem_dst = AW'(mi + 9); mem_data = 16'hB000 + 16'(mi);
            #1;
            if (rf_we) begin wcyc.push_back(c); wdat.push_back(rf_dst); end
            if (alu_vld && alu_rdy) ai++;
            if (mem_vld && mem_rdy) mi++;
            next_cycle();
        end
        idle_inputs();
        total++; if (wdat.size() != 6) begin bad++; $display("FAIL tie_count got=%0d exp=6", wdat.size()); end
        for (int i = 0; i < wdat.size() && i < 6; i++) begin
            exp_d = ((i % 2) == 0) ? (16'hA000 + 16'(i / 2)) : (16'hB000 + 16'(i / 2));
            total++; if (wdat[i] !== exp_d) begin bad++; $display("FAIL tie_order i=%0d got=%0h exp=%0h", i, wdat[i], exp_d); end
            total++; if (wcyc[i] != 2 + i) begin bad++; $display("FAIL tie_cycle i=%0d got=%0d exp=%0d", i, wcyc[i], 2 + i); end
        end
    endtask

    task automatic test_backpressure();
        int a_cnt, m_cnt, a_seq, m_seq, a_next, m_next;
        bit saw_low;
        logic [DW-1:0] exp_d;
        do_reset();
        a_cnt = 0; m_cnt = 0; a_seq = 0; m_seq = 0; a_next = 0; m_next = 0; saw_low = 0;
        for (int c = 0; c < 24; c++) begin
            alu_vld = (c < 10); alu_dst = 4'd1; alu_data = {4'hA, 12'(a_seq)};
            mem_vld = (c < 4);  mem_dst = 4'd2; mem_data = {4'hB, 12'(m_seq)};
            #1;
            if (rf_we) begin
                if (rf_dst[15:12] == 4'hA) begin
                    exp_d = {4'hA, 12'(a_next)};
                    total++; if (rf_dst !== exp_d) begin bad++; $display("FAIL bp_alu_seq got=%0h exp=%0h", rf_dst, exp_d); end
                    a_next++; a_cnt--;
                end else begin
                    exp_d = {4'hB, 12'(m_next)};
                    total++; if (rf_dst !== exp_d) begin bad++; $display("FAIL bp_mem_seq got=%0h exp=%0h", rf_dst, exp_d); end
                    m_next++; m_cnt--;
                end
            end
            total++; if (mem_rdy !== (m_cnt < DEPTH)) begin bad++; $display("FAIL bp_mem_rdy c=%0d got=%0b queued=%0d", c, mem_rdy, m_cnt); end
            total++; if (alu_rdy !== (a_cnt < DEPTH)) begin bad++; $display("FAIL bp_alu_rdy c=%0d got=%0b queued=%0d", c, alu_rdy, a_cnt); end
            if (mem_vld && !mem_rdy) saw_low = 1;
            if (alu_vld && alu_rdy) begin a_seq++; a_cnt++; end
            if (mem_vld && mem_rdy) begin m_seq++; m_cnt++; end
            next_cycle();
        end
        idle_inputs();
        total++; if (!saw_low) begin bad++; $display("FAIL bp_mem_rdy_low got=never exp=deasserted"); end
        total++; if (a_next != a_seq) begin bad++; $display("FAIL bp_alu_total got=%0d exp=%0d", a_next, a_seq); end
        total++; if (m_next != m_seq) begin bad++; $display("FAIL bp_mem_total got=%0d exp=%0d", m_next, m_seq); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL bp_idle got=%0b exp=1", idle); end
    endtask

    task automatic test_r0_discard();
        do_reset();
        alu_vld = 1; alu_dst = 4'd4; alu_data = 16'h1111;
        iss_vld = 1; iss_dst = 4'd0; rd0_addr = 4'd0;
        #1;
        total++; if (hazard0 !== 1'b0) begin bad++; $display("FAIL r0_hz_c0 got=%0b exp=0", hazard0); end
        next_cycle();
        iss_vld = 0;
        alu_dst = 4'd0; alu_data = 16'hFFFF;
        #1;
        total++; if (iss_hazard !== 1'b0) begin bad++; $display("FAIL r0_iss_hz got=%0b exp=0", iss_hazard); end
        next_cycle();
        alu_vld = 0;
        #1;
        total++; if (rf_we !== 1'b1 || rf_dst !== 16'h1111) begin bad++; $display("FAIL r0_first_write got=%0b/%0h exp=1/1111", rf_we, rf_dst); end
        total++; if (hazard0 !== 1'b0) begin bad++; $display("FAIL r0_hz_c2 got=%0b exp=0", hazard0); end
        next_cycle();
        #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL r0_we got=%0b exp=0", rf_we); end
        total++; if (rf_dst !== 16'h1111) begin bad++; $display("FAIL r0_data_hold got=%0h exp=1111", rf_dst); end
        total++; if (rf_dst_addr !== 4'd4) begin bad++; $display("FAIL r0_addr_hold got=%0h exp=4", rf_dst_addr); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL r0_idle got=%0b exp=1", idle); end
        total++; if (mem_rdy !== 1'b1) begin bad++; $display("FAIL r0_mem_rdy got=%0b exp=1", mem_rdy); end
    endtask

    task automatic test_sb_collision();
        do_reset();
        iss_vld = 1; iss_dst = 4'd7;
        next_cycle();
        iss_vld = 0; alu_vld = 1; alu_dst = 4'd7; alu_data = 16'h1234;
        next_cycle();
        alu_vld = 0; iss_dst = 4'd7;
        #1;
        total++; if (iss_hazard !== 1'b1) begin bad++; $display("FAIL sb_iss_hz got=%0b exp=1", iss_hazard); end
        next_cycle();
        iss_vld = 1; iss_dst = 4'd7;
        #1;
        total++; if (rf_we !== 1'b1 || rf_dst_addr !== 4'd7) begin bad++; $display("FAIL sb_write got=%0b/%0h exp=1/7", rf_we, rf_dst_addr); end
        next_cycle();
        iss_vld = 0; rd0_addr = 4'd7; rd1_addr = 4'd7;
        #1;
        total++; if (hazard0 !== 1'b1) begin bad++; $display("FAIL sb_set_wins_hz0 got=%0b exp=1", hazard0); end
        total++; if (hazard1 !== 1'b1) begin bad++; $display("FAIL sb_set_wins_hz1 got=%0b exp=1", hazard1); end
        total++; if (iss_hazard !== 1'b1) begin bad++; $display("FAIL sb_set_wins_iss got=%0b exp=1", iss_hazard); end
    endtask

    task automatic test_async_reset();
        int we_seen;
        do_reset();
        iss_vld = 1; iss_dst = 4'd3;
        alu_vld = 1; alu_dst = 4'd1; alu_data = 16'h0A0A;
        mem_vld = 1; mem_dst = 4'd2; mem_data = 16'h0B0B;
        next_cycle();
        iss_vld = 0;
        next_cycle();
        mem_vld = 0;
        next_cycle();
        alu_vld = 0; rd0_addr = 4'd3; rd1_addr = 4'd1;
        #1;
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL ar_pre_we got=%0b exp=1", rf_we); end
        total++; if (idle !== 1'b0) begin bad++; $display("FAIL ar_pre_idle got=%0b exp=0", idle); end
        #1;
        rst_n = 0;
        #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL ar_we got=%0b exp=0", rf_we); end
        total++; if (rf_dst_addr !== 4'd0 || rf_dst !== 16'd0) begin bad++; $display("FAIL ar_out got=%0h/%0h exp=0/0", rf_dst_addr, rf_dst); end
        total++; if (alu_rdy !== 1'b1 || mem_rdy !== 1'b1) begin bad++; $display("FAIL ar_rdy got=%0b/%0b exp=1/1", alu_rdy, mem_rdy); end
        total++; if (hazard0 !== 1'b0) begin bad++; $display("FAIL ar_hz0 got=%0b exp=0", hazard0); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL ar_idle got=%0b exp=1", idle); end
        @(negedge clk);
        rst_n = 1;
        we_seen = 0;
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            if (rf_we) we_seen++;
        end
        total++; if (we_seen != 0) begin bad++; $display("FAIL ar_post_we got=%0d exp=0", we_seen); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL ar_post_idle got=%0b exp=1", idle); end
    endtask

    task automatic test_random();
        logic [AW+DW-1:0] aq[$];
        logic [AW+DW-1:0] mq[$];
        logic [AW+DW-1:0] ent;
        bit pend[NREG];
        bit alu_last;
        bit a_hold, m_hold, took;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic e_ardy, e_mrdy, e_h0, e_h1, e_ih, e_idle;
        do_reset();
        for (int i = 0; i < NREG; i++) pend[i] = 0;
        alu_last = 0; a_hold = 0; m_hold = 0;
        e_we = 0; e_addr = '0; e_data = '0;
        for (int c = 0; c < 600; c++) begin
            if (!a_hold) begin
                alu_vld  = ($urandom_range(0, 9) < 6);
                alu_dst  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                alu_data = DW'($urandom);
            end
            if (!m_hold) begin
                mem_vld  = ($urandom_range(0, 9) < 5);
                mem_dst  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                mem_data = DW'($urandom);
            end
            iss_vld  = ($urandom_range(0, 3) == 0);
            iss_dst  = AW'($urandom);
            rd0_addr = ($urandom_range(0, 3) == 0) ? e_addr : AW'($urandom);
            rd1_addr = AW'($urandom);

            e_ardy = (aq.size() < DEPTH);
            e_mrdy = (mq.size() < DEPTH);
            e_h0   = pend[rd0_addr] && !(e_we && e_addr == rd0_addr) && (rd0_addr != 0);
            e_h1   = pend[rd1_addr] && !(e_we && e_addr == rd1_addr) && (rd1_addr != 0);
            e_ih   = pend[iss_dst] && (iss_dst != 0);
            e_idle = (aq.size() == 0) && (mq.size() == 0) && !e_we;
            #1;
            total++; if (rf_we !== e_we) begin bad++; $display("FAIL rnd_we c=%0d got=%0b exp=%0b", c, rf_we, e_we); end
            total++; if (rf_dst_addr !== e_addr) begin bad++; $display("FAIL rnd_addr c=%0d got=%0h exp=%0h", c, rf_dst_addr, e_addr); end
            total++; if (rf_dst !== e_data) begin bad++; $display("FAIL rnd_data c=%0d got=%0h exp=%0h", c, rf_dst, e_data); end
            total++; if (alu_rdy !== e_ardy) begin bad++; $display("FAIL rnd_alu_rdy c=%0d got=%0b exp=%0b", c, alu_rdy, e_ardy); end
            total++; if (mem_rdy !== e_mrdy) begin bad++; $display("FAIL rnd_mem_rdy c=%0d got=%0b exp=%0b", c, mem_rdy, e_mrdy); end
            total++; if (hazard0 !== e_h0) begin bad++; $display("FAIL rnd_hz0 c=%0d got=%0b exp=%0b", c, hazard0, e_h0); end
            total++; if (hazard1 !== e_h1) begin bad++; $display("FAIL rnd_hz1 c=%0d got=%0b exp=%0b", c, hazard1, e_h1); end
            total++; if (iss_hazard !== e_ih) begin bad++; $display("FAIL rnd_iss_hz c=%0d got=%0b exp=%0b", c, iss_hazard, e_ih); end
            total++; if (idle !== e_idle) begin bad++; $display("FAIL rnd_idle c=%0d got=%0b exp=%0b", c, idle, e_idle); end

            // Reference behaviour at the coming edge.
            took = 0; ent = '0;
            if (aq.size() != 0 && (mq.size() == 0 || !alu_last)) begin
                ent = aq.pop_front(); took = 1; alu_last = 1;
            end else if (mq.size() != 0) begin
                ent = mq.pop_front(); took = 1; alu_last = 0;
            end
            if (e_we && e_addr != 0) pend[e_addr] = 0;
            if (iss_vld && iss_dst != 0) pend[iss_dst] = 1;
            e_we = took && (ent[AW+DW-1:DW] != 0);
            if (e_we) begin
                e_addr = ent[AW+DW-1:DW];
                e_data = ent[DW-1:0];
            end
            a_hold = alu_vld && !e_ardy;
            m_hold = mem_vld && !e_mrdy;
            if (alu_vld && e_ardy) aq.push_back({alu_dst, alu_data});
            if (mem_vld && e_mrdy) mq.push_back({mem_dst, mem_data});
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_alu();
        test_tie_rr();
        test_backpressure();
        test_r0_discard();
        test_sb_collision();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
